avmm_rr_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares one Avalon-MM register-bank slave port among NREQ fabric requesters. Each requester issues a single read or write. The block latches the command and drives the master side, holding it through waitrequest. For reads it collects readdata/readdatavalid. It then returns a one-cycle completion pulse to the owner. It sits between fabric clients (DMA setup, status pollers, debug) and the register-bank slave, alongside the HPS bridge.

---
 rtl/avmm_rr_arbiter.sv | 142 ++++++++++++++
 tb/tb_avmm_rr_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/avmm_rr_arbiter.sv
// rtl/avmm_rr_arbiter.sv - round-robin arbiter sharing one Avalon-MM slave port among NREQ requesters
module avmm_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDRWIDTH = 10,
  parameter int DATAWIDTH = 64,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NREQ-1:0]                req_i,
  input  logic [NREQ-1:0]                req_write_i,
  input  logic [NREQ*ADDRWIDTH-1:0]      req_addr_i,
  input  logic [NREQ*DATAWIDTH-1:0]      req_wdata_i,
  input  logic [NREQ*(DATAWIDTH/8)-1:0]  req_byteen_i,
  output logic [NREQ-1:0]                done_o,
  output logic                           err_o,
  output logic [DATAWIDTH-1:0]           rdata_o,
  output logic                           busy_o,
  output logic                           m_read,
  output logic                           m_write,
  output logic [ADDRWIDTH-1:0]           m_address,
  output logic [DATAWIDTH-1:0]           m_writedata,
  output logic [DATAWIDTH/8-1:0]         m_byteenable,
  input  logic [DATAWIDTH-1:0]           m_readdata,
  input  logic                           m_readdatavalid,
  input  logic                           m_waitrequest
);

  localparam int BEW = DATAWIDTH / 8;
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_DONE} state_t;

  state_t          state;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            found;
  logic            is_write;
  logic [15:0]     cnt;

  logic [ADDRWIDTH-1:0] addr_a   [NREQ];
  logic [DATAWIDTH-1:0] wdata_a  [NREQ];
  logic [BEW-1:0]       byteen_a [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_a[k]   = req_addr_i[k*ADDRWIDTH +: ADDRWIDTH];
    assign wdata_a[k]  = req_wdata_i[k*DATAWIDTH +: DATAWIDTH];
    assign byteen_a[k] = req_byteen_i[k*BEW +: BEW];
  end

  // First requester strictly after last_grant, wrapping; last_grant itself is checked last.
  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(last_grant) + i) % NREQ);
      if (!found && req_i[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      grant        <= '0;
      last_grant   <= IW'(NREQ - 1);
      is_write     <= 1'b0;
      cnt          <= '0;
      done_o       <= '0;
      err_o        <= 1'b0;
      rdata_o      <= '0;
      busy_o       <= 1'b0;
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_address    <= '0;
      m_writedata  <= '0;
      m_byteenable <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant        <= pick;
            is_write     <= req_write_i[pick];
            m_write      <= req_write_i[pick];
            m_read       <= !req_write_i[pick];
            m_address    <= addr_a[pick];
            m_writedata  <= wdata_a[pick];
            m_byteenable <= byteen_a[pick];
            cnt          <= '0;
            busy_o       <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 16'd1;
          if (!m_waitrequest && (is_write || m_readdatavalid)) begin
            m_read        <= 1'b0;
            m_write       <= 1'b0;
            rdata_o       <= is_write ? '0 : m_readdata;
            done_o[grant] <= 1'b1;
            state         <= S_DONE;
          end else if (cnt >= 16'(TIMEOUT)) begin
            m_read        <= 1'b0;
            m_write       <= 1'b0;
            err_o         <= 1'b1;
            done_o[grant] <= 1'b1;
            state         <= S_DONE;
          end else if (!m_waitrequest) begin
            m_read <= 1'b0;
            state  <= S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          cnt <= cnt + 16'd1;
          if (m_readdatavalid) begin
            rdata_o       <= m_readdata;
            done_o[grant] <= 1'b1;
            state         <= S_DONE;
          end else if (cnt >= 16'(TIMEOUT)) begin
            err_o         <= 1'b1;
            done_o[grant] <= 1'b1;
            state         <= S_DONE;
          end
        end
        default: begin
          done_o     <= '0;
          err_o      <= 1'b0;
          rdata_o    <= '0;
          busy_o     <= 1'b0;
          last_grant <= grant;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avmm_rr_arbiter.sv
// tb/tb_avmm_rr_arbiter.sv - self-checking bench for avmm_rr_arbiter
module tb_avmm_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_i = '0;
  logic [3:0]  req_write_i = '0;
  logic [39:0] req_addr_i;
  logic [255:0] req_wdata_i;
  logic [31:0] req_byteen_i;
  logic [3:0]  done_o;
  logic        err_o;
  logic [63:0] rdata_o;
  logic        busy_o;
  logic        m_read, m_write;
  logic [9:0]  m_address;
  logic [63:0] m_writedata;
  logic [7:0]  m_byteenable;
  logic [63:0] m_readdata = '0;
  logic        m_readdatavalid = 1'b0;
  logic        m_waitrequest = 1'b0;

  int checks = 0;
  int errors = 0;

  avmm_rr_arbiter #(.NREQ(4), .ADDRWIDTH(10), .DATAWIDTH(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_byteen_i(req_byteen_i),
    .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .m_read(m_read), .m_write(m_write), .m_address(m_address),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req, wr;
    logic        wt, rdv;
    logic [63:0] rdin;
    logic [3:0]  done;
    logic        rd, mw, busy, err;
    logic [63:0] rdata;
    logic [9:0]  addr;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [9:0] addr_of(input int k);
    return 10'h010 + 10'(k * 'h40);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_i = '0; req_write_i = '0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 4; k++) begin
      req_addr_i[k*10 +: 10]  = addr_of(k);
      req_wdata_i[k*64 +: 64] = (k == 0) ? 64'hDEADBEEF_00000001 : {32'hCAFE0000 + 32'(k), 32'h0};
      req_byteen_i[k*8 +: 8]  = (k == 0) ? 8'hFF : 8'hF0 | 8'(k);
    end
    for (int g = 0; g < 5; g++) begin
      logic [3:0] oh;
      oh = 4'(1 << (g % 4));
      tbl[g*3]   = '{4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0, addr_of(g % 4)};
      tbl[g*3+1] = '{4'hF, 4'hF, 1'b0, 1'b0, 64'h0, oh,   1'b0, 1'b0, 1'b1, 1'b0, 64'h0, addr_of(g % 4)};
      tbl[g*3+2] = '{4'hF, 4'hF, 1'b0, 1'b0, 64'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, addr_of(g % 4)};
    end
    tbl[15] = '{4'h2, 4'h0, 1'b0, 1'b0, 64'h0,    4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h0,    10'h050};
    tbl[16] = '{4'h2, 4'h0, 1'b0, 1'b1, 64'hABCD, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 64'hABCD, 10'h050};
    tbl[17] = '{4'h0, 4'h0, 1'b0, 1'b0, 64'h0,    4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0,    10'h050};

    // reset values
    do_reset();
    chk("rst done", 64'(done_o), 0);
    chk("rst busy", 64'(busy_o), 0);
    chk("rst strobes", 64'({m_read, m_write}), 0);
    chk("rst addr", 64'(m_address), 0);
    chk("rst wdata", m_writedata, 0);
    chk("rst byteen", 64'(m_byteenable), 0);

    // single write from requester 0
    req_i = 4'h1; req_write_i = 4'h1;
    step();
    chk("wr m_write", 64'(m_write), 1);
    chk("wr m_read", 64'(m_read), 0);
    chk("wr addr", 64'(m_address), 64'h010);
    chk("wr wdata", m_writedata, 64'hDEADBEEF_00000001);
    chk("wr byteen", 64'(m_byteenable), 64'hFF);
    chk("wr done early", 64'(done_o), 0);
    step();
    chk("wr done", 64'(done_o), 64'h1);
    chk("wr err", 64'(err_o), 0);
    chk("wr strobe dropped", 64'(m_write), 0);
    req_i = 4'h0;
    step();
    chk("wr done cleared", 64'(done_o), 0);
    chk("wr idle", 64'(busy_o), 0);

    // fairness and same-cycle readdatavalid
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req_i = tbl[i].req; req_write_i = tbl[i].wr;
      m_waitrequest = tbl[i].wt; m_readdatavalid = tbl[i].rdv; m_readdata = tbl[i].rdin;
      step();
      chk($sformatf("v%0d done", i), 64'(done_o), 64'(tbl[i].done));
      chk($sformatf("v%0d read", i), 64'(m_read), 64'(tbl[i].rd));
      chk($sformatf("v%0d write", i), 64'(m_write), 64'(tbl[i].mw));
      chk($sformatf("v%0d busy", i), 64'(busy_o), 64'(tbl[i].busy));
      chk($sformatf("v%0d err", i), 64'(err_o), 64'(tbl[i].err));
      chk($sformatf("v%0d rdata", i), rdata_o, tbl[i].rdata);
      chk($sformatf("v%0d addr", i), 64'(m_address), 64'(tbl[i].addr));
    end
    m_readdatavalid = 1'b0; m_readdata = '0;

    // read with waitrequest stall then delayed readdatavalid (requester 2)
    req_i = 4'h4; req_write_i = 4'h0; m_waitrequest = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d read", i), 64'(m_read), 1);
      chk($sformatf("stall%0d addr", i), 64'(m_address), 64'h090);
      chk($sformatf("stall%0d done", i), 64'(done_o), 0);
      req_i = 4'h4; req_write_i = 4'h4;
      step();
    end
    chk("stall last read", 64'(m_read), 1);
    chk("stall last addr", 64'(m_address), 64'h090);
    m_waitrequest = 1'b0;
    step();
    chk("waitrd strobe", 64'(m_read), 0);
    chk("waitrd busy", 64'(busy_o), 1);
    step();
    chk("waitrd done", 64'(done_o), 0);
    m_readdatavalid = 1'b1; m_readdata = 64'h1234;
    step();
    chk("stall rd done", 64'(done_o), 64'h4);
    chk("stall rd rdata", rdata_o, 64'h1234);
    m_readdatavalid = 1'b0; m_readdata = '0; req_i = 4'h0;
    step();
    chk("stall rd rdata cleared", rdata_o, 0);

    // timeout on requester 3
    req_i = 4'h8; req_write_i = 4'h8; m_waitrequest = 1'b1;
    step();
    chk("to issue", 64'(m_write), 1);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (done_o != 4'h0) begin
        n = i;
        break;
      end
    end
    chk("to latency", 64'(n), 9);
    chk("to done", 64'(done_o), 64'h8);
    chk("to err", 64'(err_o), 1);
    chk("to strobes", 64'({m_read, m_write}), 0);
    chk("to rdata", rdata_o, 0);
    req_i = 4'h0; m_waitrequest = 1'b0;
    step();
    chk("to err cleared", 64'(err_o), 0);

    // async reset while in WAIT_RD
    do_reset();
    req_i = 4'h2; req_write_i = 4'h0;
    step();
    chk("mr issue", 64'(m_read), 1);
    step();
    chk("mr waitrd busy", 64'(busy_o), 1);
    #2 rst = 1'b1;
    #1;
    chk("mr busy", 64'(busy_o), 0);
    chk("mr outs", 64'({done_o, err_o, m_read, m_write}), 0);
    chk("mr addr", 64'(m_address), 0);
    req_i = 4'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    req_i = 4'h4; req_write_i = 4'h0;
    step();
    chk("mr2 read", 64'(m_read), 1);
    chk("mr2 addr", 64'(m_address), 64'h090);
    m_readdatavalid = 1'b1; m_readdata = 64'h55;
    step();
    chk("mr2 done", 64'(done_o), 64'h4);
    chk("mr2 rdata", rdata_o, 64'h55);
    chk("mr2 err", 64'(err_o), 0);
    req_i = 4'h0; m_readdatavalid = 1'b0;
    step();
    chk("mr2 done cleared", 64'(done_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
